// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-table sequencer.
package sccb_pkg;

  // Table-walk states of the top-level sequencer.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_WRITE  = 3'd3,
    S_WAIT   = 3'd4,
    S_FINISH = 3'd5
  } seq_state_e;

  // Bus-level states of the 3-phase write engine.
  typedef enum logic [2:0] {
    E_IDLE  = 3'd0,
    E_START = 3'd1,
    E_BITS  = 3'd2,
    E_STOP  = 3'd3,
    E_GAP   = 3'd4
  } eng_state_e;

  // Table markers.
  localparam logic [15:0] END_MARKER   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARKER = 16'hFFF0;

  // Three bytes of 8 data bits plus one ack bit each.
  localparam int          BITS_PER_WRITE = 27;
  localparam logic [3:0]  ACK_BIT        = 4'd8;

  // Quarter phases of one SCL period.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/sccb_write_engine.sv
// One SCCB 3-phase write: start condition, 27 bits, stop condition, one idle
// quarter. Handshake: word_i is accepted on a cycle where go_i and ready_o are
// both high; ready_o is high exactly while idle and never depends on go_i.
// done_o pulses in the final cycle of the idle gap quarter.
module sccb_write_engine
  import sccb_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go_i,
  input  logic [23:0] word_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        nack_o,
  output logic        scl_o,
  output logic        sda_oe_o,
  input  logic        sda_i,
  output eng_state_e  state_o
);

  localparam int DW = $clog2(CLK_DIV);

  eng_state_e  state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [4:0]  bit_q, bit_d;
  logic [3:0]  bib_q, bib_d;
  logic [23:0] sh_q, sh_d;
  logic        scl_q, scl_d;
  logic        sda_oe_q, sda_oe_d;
  logic        tick;

  assign tick     = (div_q == DW'(CLK_DIV - 1));
  assign scl_o    = scl_q;
  assign sda_oe_o = sda_oe_q;
  assign state_o  = state_q;

  // State register; reset releases the bus immediately with no stop condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= E_IDLE;
      div_q    <= '0;
      qtr_q    <= Q0;
      bit_q    <= '0;
      bib_q    <= '0;
      sh_q     <= '0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      bib_q    <= bib_d;
      sh_q     <= sh_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  // Next state: pin levels for a quarter are registered at its first cycle.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    bib_d    = bib_q;
    sh_d     = sh_q;
    scl_d    = scl_q;
    sda_oe_d = sda_oe_q;
    ready_o  = 1'b0;
    done_o   = 1'b0;
    nack_o   = 1'b0;
    if (state_q != E_IDLE) div_d = tick ? '0 : div_q + DW'(1);
    case (state_q)
      E_IDLE: begin
        ready_o  = 1'b1;
        div_d    = '0;
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        if (go_i) begin
          state_d  = E_START;
          qtr_d    = Q0;
          sh_d     = word_i;
          sda_oe_d = 1'b1;            // SDA falls while SCL is high
        end
      end
      E_START: if (tick) begin
        if (qtr_q == Q0) begin
          qtr_d = Q1;
          scl_d = 1'b0;
        end else begin
          state_d  = E_BITS;
          qtr_d    = Q0;
          bit_d    = '0;
          bib_d    = '0;
          sda_oe_d = ~sh_q[23];
        end
      end
      E_BITS: if (tick) begin
        case (qtr_q)
          Q0: qtr_d = Q1;
          Q1: begin
            qtr_d = Q2;
            scl_d = 1'b1;
          end
          Q2: begin
            qtr_d = Q3;
            if (bib_q == ACK_BIT && sda_i) nack_o = 1'b1;
          end
          default: begin
            qtr_d = Q0;
            scl_d = 1'b0;
            if (bit_q == 5'(BITS_PER_WRITE - 1)) begin
              state_d  = E_STOP;
              sda_oe_d = 1'b1;
            end else begin
              bit_d = bit_q + 5'd1;
              if (bib_q == ACK_BIT) begin
                bib_d    = '0;
                sda_oe_d = ~sh_q[23];
              end else begin
                sh_d     = {sh_q[22:0], 1'b0};
                bib_d    = bib_q + 4'd1;
                // Release SDA for the slave's ack slot.
                sda_oe_d = (bib_q == ACK_BIT - 4'd1) ? 1'b0 : ~sh_q[22];
              end
            end
          end
        endcase
      end
      E_STOP: if (tick) begin
        case (qtr_q)
          Q0: begin
            qtr_d = Q1;
            scl_d = 1'b1;
          end
          Q1: begin
            qtr_d    = Q2;
            sda_oe_d = 1'b0;           // SDA rises while SCL is high
          end
          default: begin
            state_d = E_GAP;
            qtr_d   = Q0;
          end
        endcase
      end
      E_GAP: if (tick) begin
        state_d = E_IDLE;
        done_o  = 1'b1;
      end
      default: state_d = E_IDLE;
    endcase
  end

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks a register table in an external synchronous ROM and writes each entry
// to the camera sensor over SCCB; handles end and delay markers.
module sccb_config_sequencer
  import sccb_pkg::*;
#(
  parameter int          CLK_DIV      = 125,
  parameter logic [7:0]  DEVICE_ID    = 8'h42,
  parameter int          ROM_DEPTH    = 256,
  parameter int          DELAY_CYCLES = 500000,
  localparam int         AW           = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          scl,
  output logic          sda_oe,
  input  logic          sda_i,
  output logic          busy,
  output logic          done,
  output logic          nack_err,
  output seq_state_e    dbg_state,
  output eng_state_e    dbg_eng_state
);

  localparam int DLW = $clog2(DELAY_CYCLES + 1);

  seq_state_e     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DLW-1:0] delay_q, delay_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           nack_q, nack_d;
  logic           eng_go, eng_ready, eng_done, eng_nack;

  assign rom_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nack_err  = nack_q;
  assign dbg_state = state_q;

  sccb_write_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk      (clk),
    .reset    (reset),
    .go_i     (eng_go),
    .word_i   ({DEVICE_ID, rom_data}),
    .ready_o  (eng_ready),
    .done_o   (eng_done),
    .nack_o   (eng_nack),
    .scl_o    (scl),
    .sda_oe_o (sda_oe),
    .sda_i    (sda_i),
    .state_o  (dbg_eng_state)
  );

  // State register and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      delay_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      delay_q <= delay_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
    end
  end

  // Table walk. rom_data for the new address is valid in DECODE, one cycle
  // after FETCH presents it; the engine latches the full word on go.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    delay_d = delay_q;
    busy_d  = busy_q;
    done_d  = done_q;
    nack_d  = nack_q | eng_nack;
    eng_go  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        busy_d  = 1'b1;
        done_d  = 1'b0;
        nack_d  = 1'b0;
        addr_d  = '0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data == END_MARKER) begin
          state_d = S_FINISH;
        end else if (rom_data == DELAY_MARKER) begin
          delay_d = '0;
          state_d = S_WAIT;
        end else if (eng_ready) begin
          eng_go  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: if (eng_done) begin
        if (addr_q == AW'(ROM_DEPTH - 1)) begin
          state_d = S_FINISH;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (delay_q == DLW'(DELAY_CYCLES - 1)) begin
          if (addr_q == AW'(ROM_DEPTH - 1)) begin
            state_d = S_FINISH;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = S_FETCH;
          end
        end else begin
          delay_d = delay_q + DLW'(1);
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: table-driven walks against a 1-cycle ROM
// and an SCCB slave model, plus hand sequences for reset and start corners.
module tb_sccb_config_sequencer;
  import sccb_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data;
  logic        scl;
  logic        sda_oe;
  logic        sda_i;
  logic        busy;
  logic        done;
  logic        nack_err;
  seq_state_e  dbg_state;
  eng_state_e  dbg_eng_state;

  int checks = 0;
  int errors = 0;

  // ROM and slave model state
  logic [15:0] rom_mem [4];
  logic        slave_pull = 1'b0;
  logic        slave_clr  = 1'b0;
  int          nack_byte  = -1;
  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];
  logic        in_frame = 1'b0;
  int          bitn = 0;
  int          frame_bytes = 0;
  int          byte_cnt = 0;
  logic [7:0]  shreg = '0;
  int          run_len = 0;
  int          max_run = 0;
  int          bus_viol = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        prev_oe  = 1'b0;
  logic        prev_rst = 1'b1;
  logic        sda_now;

  typedef struct packed {
    logic [3:0][15:0] rom;
    int               nack_byte;
    int               exp_busy;
    logic [1:0]       exp_addr;
    logic             exp_nack;
    logic             exp_long_gap;
  } vec_t;

  vec_t vecs [4];

  sccb_config_sequencer #(
    .CLK_DIV      (4),
    .DEVICE_ID    (8'h42),
    .ROM_DEPTH    (4),
    .DELAY_CYCLES (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .scl           (scl),
    .sda_oe        (sda_oe),
    .sda_i         (sda_i),
    .busy          (busy),
    .done          (done),
    .nack_err      (nack_err),
    .dbg_state     (dbg_state),
    .dbg_eng_state (dbg_eng_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Synchronous ROM with one cycle of read latency
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Open-drain SDA: low if either side pulls
  assign sda_i = ~(sda_oe | slave_pull);

  // SCCB slave model, bus-rule monitor and SCL-high run tracker
  always @(negedge clk) begin
    sda_now = ~(sda_oe | slave_pull);
    if (slave_clr) begin
      in_frame    = 1'b0;
      bitn        = 0;
      frame_bytes = 0;
      byte_cnt    = 0;
      slave_pull  = 1'b0;
      run_len     = 0;
      max_run     = 0;
      got_q.delete();
    end else begin
      // SDA may only move under high SCL as a start (outside a frame) or stop.
      if (!reset && !prev_rst && prev_scl && scl && (sda_oe != prev_oe)) begin
        if (!((sda_oe && !in_frame) || (!sda_oe && in_frame && frame_bytes == 3)))
          bus_viol++;
      end
      if (prev_scl && scl && prev_sda && !sda_now) begin
        in_frame    = 1'b1;
        bitn        = 0;
        frame_bytes = 0;
      end else if (prev_scl && scl && !prev_sda && sda_now) begin
        in_frame = 1'b0;
      end else if (in_frame && !prev_scl && scl) begin
        if (bitn < 8) begin
          shreg = {shreg[6:0], sda_now};
          bitn++;
          if (bitn == 8) begin
            got_q.push_back(shreg);
            byte_cnt++;
            frame_bytes++;
          end
        end else begin
          bitn = 0;
        end
      end else if (in_frame && prev_scl && !scl) begin
        slave_pull = (bitn == 8) && ((byte_cnt - 1) != nack_byte);
      end
      if (busy && scl) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
    end
    prev_scl = scl;
    prev_sda = sda_now;
    prev_oe  = sda_oe;
    prev_rst = reset;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_slave();
    slave_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    slave_clr = 1'b0;
  endtask

  task automatic load_table(input vec_t v);
    for (int i = 0; i < 4; i++) rom_mem[i] = v.rom[i];
    nack_byte = v.nack_byte;
  endtask

  // Apply one table, optionally pulse start again at busy cycle pulse_at.
  task automatic run_vec(input string tag, input vec_t v, input int pulse_at);
    int   cnt;
    int   n_exp;
    logic ended;
    logic [7:0] e;
    logic [7:0] g;
    load_table(v);
    exp_q.delete();
    ended = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v.rom[i] == 16'hFFFF) ended = 1'b1;
      if (!ended && v.rom[i] != 16'hFFF0) begin
        exp_q.push_back(8'h42);
        exp_q.push_back(v.rom[i][15:8]);
        exp_q.push_back(v.rom[i][7:0]);
      end
    end
    clear_slave();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 4000) begin
      cnt++;
      start = (cnt == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_no_timeout"}, int'(cnt < 4000), 1);
    check({tag, "_busy_cycles"}, cnt, v.exp_busy);
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_nack_err"}, int'(nack_err), int'(v.exp_nack));
    check({tag, "_rom_addr"}, int'(rom_addr), int'(v.exp_addr));
    check({tag, "_long_scl_gap"}, int'(max_run >= 100), int'(v.exp_long_gap));
    n_exp = exp_q.size();
    check({tag, "_byte_count"}, got_q.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hXX;
      check($sformatf("%s_byte%0d", tag, i), int'(g), int'(e));
    end
  endtask

  initial begin
    int cnt;
    // Vector table: ROM image, nacked byte index, expected results.
    vecs[0].rom = '0;
    vecs[0].rom[0] = 16'h1280; vecs[0].rom[1] = 16'hFFFF;
    vecs[0].nack_byte = -1; vecs[0].exp_busy = 461;  vecs[0].exp_addr = 2'd1;
    vecs[0].exp_nack = 1'b0; vecs[0].exp_long_gap = 1'b0;

    vecs[1].rom[0] = 16'h1280; vecs[1].rom[1] = 16'hFFF0;
    vecs[1].rom[2] = 16'h1104; vecs[1].rom[3] = 16'hFFFF;
    vecs[1].nack_byte = -1; vecs[1].exp_busy = 1021; vecs[1].exp_addr = 2'd3;
    vecs[1].exp_nack = 1'b0; vecs[1].exp_long_gap = 1'b1;

    vecs[2].rom = '0;
    vecs[2].rom[0] = 16'h1280; vecs[2].rom[1] = 16'h1104; vecs[2].rom[2] = 16'hFFFF;
    vecs[2].nack_byte = 2;  vecs[2].exp_busy = 919;  vecs[2].exp_addr = 2'd2;
    vecs[2].exp_nack = 1'b1; vecs[2].exp_long_gap = 1'b0;

    vecs[3].rom[0] = 16'h1280; vecs[3].rom[1] = 16'h1104;
    vecs[3].rom[2] = 16'h1501; vecs[3].rom[3] = 16'h3A0C;
    vecs[3].nack_byte = -1; vecs[3].exp_busy = 1833; vecs[3].exp_addr = 2'd3;
    vecs[3].exp_nack = 1'b0; vecs[3].exp_long_gap = 1'b0;

    // Reset
    for (int i = 0; i < 4; i++) rom_mem[i] = 16'hFFFF;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scl", int'(scl), 1);
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_nack_err", int'(nack_err), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_scl", int'(scl), 1);
    check("post_rst_busy", int'(busy), 0);

    // Table-driven walks
    for (int i = 0; i < 4; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i], 0);
      repeat (5) @(negedge clk);
    end

    // Start pulse while busy must not restart the walk
    run_vec("busy_start", vecs[3], 600);
    repeat (5) @(negedge clk);

    // Start in the FINISH cycle is ignored
    load_table(vecs[0]);
    clear_slave();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (dbg_state != S_FINISH && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check("fin_reached", int'(cnt < 2000), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fin_start_busy", int'(busy), 0);
    check("fin_start_done", int'(done), 1);
    @(negedge clk);
    check("fin_start_idle", int'(dbg_state == S_IDLE), 1);
    check("fin_start_busy2", int'(busy), 0);
    repeat (5) @(negedge clk);

    // Reset during write bit 10, then replay from entry 0
    load_table(vecs[2]);
    clear_slave();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (175) @(negedge clk);
    check("pre_rst_scl_low", int'(scl), 0);
    check("pre_rst_sda_oe", int'(sda_oe), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_scl", int'(scl), 1);
    check("mid_rst_sda_oe", int'(sda_oe), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_vec("replay", vecs[0], 0);
    repeat (5) @(negedge clk);

    check("bus_rule_violations", bus_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
